data_island_packet_scheduler: RTL

DATA_ISLAND_PACKET_SCHEDULER -- requirements
Module: data_island_packet_scheduler

---
 rtl/data_island_packet_scheduler_if.sv | 21 ++
 rtl/data_island_packet_scheduler.sv | 116 +++++++++++
 2 files changed

// File: rtl/data_island_packet_scheduler_if.sv
// Packet bus for the data-island scheduler: audio sample packet handshake in,
// selected packet out.
interface data_island_packet_scheduler_if;
  logic             asp_valid;
  logic             asp_ready;
  logic [23:0]      asp_header;
  logic [3:0][55:0] asp_sub;
  logic [23:0]      header;
  logic [3:0][55:0] sub;
  logic [7:0]       packet_type;

  modport master (
    output asp_valid, asp_header, asp_sub,
    input  asp_ready, header, sub, packet_type
  );

  modport slave (
    input  asp_valid, asp_header, asp_sub,
    output asp_ready, header, sub, packet_type
  );
endinterface

// File: rtl/data_island_packet_scheduler.sv
// Picks one packet (ACR > ASP > AVI > AIF > null) for every data-island slot.
// Optional feature macro: AUDIO_INFOFRAME_EN enables audio infoframe scheduling.
module data_island_packet_scheduler #(
  parameter int FIELDS_PER_INFOFRAME = 1
) (
  input  logic                           clk_pixel,
  input  logic                           reset,
  input  logic                           packet_enable,
  input  logic                           video_field_end,
  input  logic                           acr_wrap,
  input  logic [23:0]                    acr_header,
  input  logic [3:0][55:0]               acr_sub,
  input  logic [23:0]                    avi_header,
  input  logic [3:0][55:0]               avi_sub,
  input  logic [23:0]                    aif_header,
  input  logic [3:0][55:0]               aif_sub,
  output logic                           acr_overrun,
  data_island_packet_scheduler_if.slave  pkt
);

  localparam logic [3:0] LAST_FIELD = 4'(FIELDS_PER_INFOFRAME - 1);

  logic             acr_wrap_q;
  logic             acr_pending;
  logic             avi_pending;
  logic             aif_pending;
  logic [3:0]       field_cnt;
  logic             acr_req;
  logic             field_wrap;
  logic             sel_acr, sel_asp, sel_avi, sel_aif;
  logic [7:0]       nxt_type;
  logic [23:0]      nxt_header;
  logic [3:0][55:0] nxt_sub;

  assign acr_req    = acr_wrap ^ acr_wrap_q;
  assign field_wrap = video_field_end && (field_cnt == LAST_FIELD);

  always_comb begin
    sel_acr = packet_enable && acr_pending;
    sel_asp = packet_enable && !acr_pending && pkt.asp_valid;
    sel_avi = packet_enable && !acr_pending && !pkt.asp_valid && avi_pending;
    sel_aif = packet_enable && !acr_pending && !pkt.asp_valid && !avi_pending && aif_pending;
  end

  assign pkt.asp_ready = sel_asp && !reset;

  always_comb begin
    nxt_type   = 8'h00;
    nxt_header = '0;
    nxt_sub    = '0;
    if (sel_acr) begin
      nxt_type   = 8'h01;
      nxt_header = acr_header;
      nxt_sub    = acr_sub;
    end else if (sel_asp) begin
      nxt_type   = 8'h02;
      nxt_header = pkt.asp_header;
      nxt_sub    = pkt.asp_sub;
    end else if (sel_avi) begin
      nxt_type   = 8'h82;
      nxt_header = avi_header;
      nxt_sub    = avi_sub;
    end else if (sel_aif) begin
      nxt_type   = 8'h84;
      nxt_header = aif_header;
      nxt_sub    = aif_sub;
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      acr_wrap_q      <= acr_wrap;
      acr_pending     <= 1'b0;
      acr_overrun     <= 1'b0;
      avi_pending     <= 1'b0;
      field_cnt       <= '0;
      pkt.header      <= '0;
      pkt.sub         <= '0;
      pkt.packet_type <= 8'h00;
    end else begin
      acr_wrap_q <= acr_wrap;
      // A request landing on an ACR selection re-arms the flag rather than being lost.
      if (acr_req)
        acr_pending <= 1'b1;
      else if (sel_acr)
        acr_pending <= 1'b0;
      if (acr_req && acr_pending && !sel_acr)
        acr_overrun <= 1'b1;
      if (video_field_end)
        field_cnt <= field_wrap ? 4'd0 : field_cnt + 4'd1;
      if (field_wrap)
        avi_pending <= 1'b1;
      else if (sel_avi)
        avi_pending <= 1'b0;
      if (packet_enable) begin
        pkt.header      <= nxt_header;
        pkt.sub         <= nxt_sub;
        pkt.packet_type <= nxt_type;
      end
    end
  end

`ifdef AUDIO_INFOFRAME_EN
  always_ff @(posedge clk_pixel) begin
    if (reset)
      aif_pending <= 1'b0;
    else if (field_wrap)
      aif_pending <= 1'b1;
    else if (sel_aif)
      aif_pending <= 1'b0;
  end
`else
  assign aif_pending = 1'b0;
`endif

endmodule
